// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-digit blink and HH:MM colon.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the leftmost digit when it is zero.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_mask,
    input  logic       colon,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_TICKS - 1);

    logic [CW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    scan_idx;
    logic          blink_phase;
    logic          tick;
    logic          blink_wrap;

    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    bcd_to_seg = 7'b1000000;
            4'd1:    bcd_to_seg = 7'b1111001;
            4'd2:    bcd_to_seg = 7'b0100100;
            4'd3:    bcd_to_seg = 7'b0110000;
            4'd4:    bcd_to_seg = 7'b0011001;
            4'd5:    bcd_to_seg = 7'b0010010;
            4'd6:    bcd_to_seg = 7'b0000010;
            4'd7:    bcd_to_seg = 7'b1111000;
            4'd8:    bcd_to_seg = 7'b0000000;
            4'd9:    bcd_to_seg = 7'b0010000;
            default: bcd_to_seg = 7'b1111111;
        endcase
    endfunction

    // Counters only advance while enabled, so a disabled display resumes exactly where it stopped.
    assign tick       = en && (refresh_cnt == REFRESH_MAX);
    assign blink_wrap = tick && (blink_cnt == BLINK_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            scan_idx    <= 2'd0;
            blink_phase <= 1'b0;
        end else if (en) begin
            refresh_cnt <= tick ? '0 : refresh_cnt + CW'(1);
            if (tick) begin
                scan_idx <= scan_idx + 2'd1;
                if (blink_wrap) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cur_digit = digit0;
        case (scan_idx)
            2'd0:    cur_digit = digit0;
            2'd1:    cur_digit = digit1;
            2'd2:    cur_digit = digit2;
            default: cur_digit = digit3;
        endcase

        cur_blank = blink_mask[scan_idx] && blink_phase;
`ifdef LEADING_ZERO_BLANK_EN
        if (scan_idx == 2'd3 && digit3 == 4'd0)
            cur_blank = 1'b1;
`endif

        an_next = 4'b1111;
        if (!cur_blank)
            an_next[scan_idx] = 1'b0;

        seg_next = bcd_to_seg(cur_digit);
        dp_next  = !(scan_idx == 2'd2 && colon);
    end

    // Registered outputs: one clk from any index or input change to the pins.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: slot table plus mid-slot, disable and reset sequences.
// A second instance with a longer blink period exposes digit-0 blinking against the scan order.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       reset, en, colon;
    logic [3:0] digit0, digit1, digit2, digit3, blink_mask;
    logic [6:0] seg, seg2;
    logic       dp, dp2;
    logic [3:0] an, an2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ_AN = 4'b1111;
`else
    localparam logic [3:0] LZ_AN = 4'b0111;
`endif

    seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_TICKS(2)) dut (
        .clk(clk), .reset(reset), .en(en),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .blink_mask(blink_mask), .colon(colon),
        .seg(seg), .dp(dp), .an(an)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_TICKS(3)) dut2 (
        .clk(clk), .reset(reset), .en(en),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .blink_mask(blink_mask), .colon(colon),
        .seg(seg2), .dp(dp2), .an(an2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d3, d2, d1, d0, mask;
        logic       colon;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [3:0] exp_an2;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [3:0] d3, d2, d1, d0, mask, input logic c,
                                input logic [3:0] a, input logic [6:0] s, input logic p,
                                input logic [3:0] a2);
        vec_t v;
        v.d3 = d3; v.d2 = d2; v.d1 = d1; v.d0 = d0; v.mask = mask; v.colon = c;
        v.exp_an = a; v.exp_seg = s; v.exp_dp = p; v.exp_an2 = a2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] a, input logic [6:0] s,
                             input logic p);
        check({name, "_an"},  {28'd0, an},  {28'd0, a});
        check({name, "_seg"}, {25'd0, seg}, {25'd0, s});
        check({name, "_dp"},  {31'd0, dp},  {31'd0, p});
    endtask

    task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
        digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    endtask

    initial begin
        // Slot n (n>=1) covers edges 4n+1..4n+4 after reset release; index is n mod 4.
        vecs[0]  = mk(1, 2, 3,    4, 4'b0000, 0, 4'b1101, 7'b0110000, 1, 4'b1101);
        vecs[1]  = mk(1, 2, 3,    4, 4'b0000, 0, 4'b1011, 7'b0100100, 1, 4'b1011);
        vecs[2]  = mk(1, 2, 3,    4, 4'b0000, 0, 4'b0111, 7'b1111001, 1, 4'b0111);
        vecs[3]  = mk(1, 2, 3,    4, 4'b0001, 0, 4'b1110, 7'b0011001, 1, 4'b1111);
        vecs[4]  = mk(1, 2, 3,    4, 4'b0001, 0, 4'b1101, 7'b0110000, 1, 4'b1101);
        vecs[5]  = mk(1, 2, 3,    4, 4'b0100, 1, 4'b1111, 7'b0100100, 0, 4'b1011);
        vecs[6]  = mk(1, 2, 3,    4, 4'b0000, 1, 4'b0111, 7'b1111001, 1, 4'b0111);
        vecs[7]  = mk(1, 2, 3,    4, 4'b0000, 1, 4'b1110, 7'b0011001, 1, 4'b1110);
        vecs[8]  = mk(1, 2, 4'hC, 4, 4'b0000, 0, 4'b1101, 7'b1111111, 1, 4'b1101);
        vecs[9]  = mk(1, 9, 4'hC, 4, 4'b0000, 0, 4'b1011, 7'b0010000, 1, 4'b1011);
        vecs[10] = mk(0, 9, 4'hC, 4, 4'b0000, 0, LZ_AN,   7'b1000000, 1, LZ_AN);
        vecs[11] = mk(0, 9, 4'hC, 7, 4'b0000, 0, 4'b1110, 7'b1111000, 1, 4'b1110);
        vecs[12] = mk(0, 9, 5,    7, 4'b0000, 0, 4'b1101, 7'b0010010, 1, 4'b1101);
        vecs[13] = mk(0, 6, 5,    7, 4'b0000, 1, 4'b1011, 7'b0000010, 0, 4'b1011);
        vecs[14] = mk(8, 6, 5,    7, 4'b0000, 1, 4'b0111, 7'b0000000, 1, 4'b0111);
        vecs[15] = mk(8, 6, 5,    3, 4'b0001, 1, 4'b1110, 7'b0110000, 1, 4'b1111);

        reset = 1'b1; en = 1'b1; colon = 1'b0; blink_mask = 4'b0000;
        set_digits(1, 2, 3, 4);

        repeat (3) begin
            step();
            check_out("reset", 4'b1111, 7'b1111111, 1'b1);
        end
        reset = 1'b0;

        for (int e = 0; e < 4; e++) begin
            step();
            check_out($sformatf("first_slot_e%0d", e), 4'b1110, 7'b0011001, 1'b1);
        end

        for (int v = 0; v < 16; v++) begin
            set_digits(vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0);
            blink_mask = vecs[v].mask;
            colon      = vecs[v].colon;
            for (int k = 0; k < 4; k++) begin
                step();
                check_out($sformatf("slot%0d_e%0d", v + 1, k), vecs[v].exp_an,
                          vecs[v].exp_seg, vecs[v].exp_dp);
                check($sformatf("slot%0d_e%0d_an2", v + 1, k), {28'd0, an2},
                      {28'd0, vecs[v].exp_an2});
                check($sformatf("slot%0d_e%0d_seg2", v + 1, k), {25'd0, seg2},
                      {25'd0, vecs[v].exp_seg});
                check($sformatf("slot%0d_e%0d_dp2", v + 1, k), {31'd0, dp2},
                      {31'd0, vecs[v].exp_dp});
            end
        end

        // Slot 17 (index 1), then mid-slot colon / blink / digit changes in slot 18 (index 2).
        set_digits(1, 2, 3, 4);
        blink_mask = 4'b0000;
        colon      = 1'b0;
        repeat (4) step();
        check_out("slot17_end", 4'b1101, 7'b0110000, 1'b1);
        step();
        check_out("mid_start", 4'b1011, 7'b0100100, 1'b1);
        colon = 1'b1;
        step();
        check_out("mid_colon", 4'b1011, 7'b0100100, 1'b0);
        blink_mask = 4'b0100;
        step();
        check_out("mid_blink_on", 4'b1111, 7'b0100100, 1'b0);
        blink_mask = 4'b0000;
        digit2     = 4'd5;
        step();
        check_out("mid_blink_off_digit", 4'b1011, 7'b0010010, 1'b0);
        colon = 1'b0;

        // Slot 19 (index 3): drop enable after its first edge, hold, then resume.
        step();
        check_out("pre_disable", 4'b0111, 7'b1111001, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check_out($sformatf("disabled_e%0d", k), 4'b1111, 7'b1111111, 1'b1);
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("resume_e%0d", k), 4'b0111, 7'b1111001, 1'b1);
        end
        step();
        check_out("resume_next_slot", 4'b1110, 7'b0011001, 1'b1);

        // Reset one edge into a slot, then a fresh full slot 0 and the step to index 1.
        reset = 1'b1;
        step();
        check_out("midslot_reset", 4'b1111, 7'b1111111, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_out($sformatf("post_reset_e%0d", k), 4'b1110, 7'b0011001, 1'b1);
        end
        step();
        check_out("post_reset_slot1", 4'b1101, 7'b0110000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream of the 4-bit digit selectors: takes the four selected BCD digits (time or alarm) and drives a 4-digit common-anode seven-segment display.
- Time-multiplexes the digits with a refresh prescaler and decodes BCD to segments.
- Blanks digits flagged for blinking during setting modes and drives the HH:MM colon through the decimal point.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives a 1 kHz slot rate). Legal range 2 to 2^20.
- BLINK_TICKS, 250, refresh ticks per blink half-period. Legal range 1 to 2^12.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  1  display enable
- digit0  input  4  rightmost digit (minutes units)
- digit1  input  4  minutes tens
- digit2  input  4  hours units
- digit3  input  4  leftmost digit (hours tens)
- blink_mask  input  4  bit i=1 blinks digit i
- colon  input  1  1 lights the colon dp on digit2
- seg  output  7  {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low
- an  output  4  anode enables, active low, an[i] selects digit i

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high and has priority over every other input.
  - Reset values: refresh counter 0, scan index 0, blink counter 0, blink_phase 0, an=4'b1111, seg=7'b1111111, dp=1.
- Refresh prescaler:
  - Counts 0 to REFRESH_DIV-1 and wraps.
  - tick is asserted for one cycle when the count equals REFRESH_DIV-1.
- Scan index:
  - 2-bit counter that advances on tick: 0,1,2,3,0, and so on.
- Blink:
  - The blink counter counts ticks from 0 to BLINK_TICKS-1.
  - On the tick where it wraps, blink_phase toggles.
  - blink_phase=1 is the "off" half-period.
- Output register, updated every clk from the current index i and current inputs (one clk latency from an input change or index change to the outputs):
  - an: an[i]=0 and all other bits 1. If blink_mask[i]=1 and blink_phase=1, an=4'b1111.
  - seg decode (active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10 to 15 give 1111111 (blank).
  - dp=0 only when i=2 and colon=1. The colon is not affected by blink_mask.
- en=0:
  - Counters hold their values.
  - an=4'b1111, seg=7'b1111111, dp=1 from the next clk.
  - When en returns to 1, scanning resumes from the held index.
- Boundary conditions:
  - Reset asserted mid-slot: outputs go to their reset values on that edge. On the first clk after reset is released, the outputs show digit 0.
  - Tick coinciding with blink wrap: index and blink_phase both change on the same edge, and the outputs reflect both one clk later.
  - blink_mask or colon changing mid-slot: takes effect one clk later with no waiting for the slot boundary.
  - Input digits are not latched per slot. They are sampled every clk.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when digit3==0, digit 3 is shown blank (an[3] stays 1 in its slot) regardless of blink. Digits 2 to 0 are never suppressed.
- Undefined: digit3==0 displays "0" like any other digit.

Test Plan:
- Reset and first slot:
  - Stimulus: REFRESH_DIV=4, BLINK_TICKS=2; assert reset for 3 clk; digits 1,2,3,4 (digit3 to digit0); en=1.
  - Required response: an=1111, seg=1111111, dp=1 during reset. One clk after release: an=1110, seg=0011001 (4).
- Scan order:
  - Stimulus: same setup as above.
  - Required response: every 4 clk an steps 1110, 1101, 1011, 0111, 1110. seg shows 4, 3, 2, 1 in turn.
- Blink:
  - Stimulus: blink_mask=4'b0001.
  - Required response: digit0 slot shows an=1111 during blink_phase=1, which spans 2 ticks = 8 clk. The other digits are unaffected.
- Colon:
  - Stimulus: colon=1.
  - Required response: dp=0 only in the an=1011 slot.
- Invalid codes and disable:
  - Stimulus: digit1=4'hC, then deassert en mid-slot.
  - Required response: slot 1 gives seg=1111111. After the en drop, outputs go blank one clk later and the index holds. Re-enabling resumes on the same index.
- Leading-zero blanking:
  - Stimulus: with LEADING_ZERO_BLANK_EN defined, digit3=0.
  - Required response: slot 3 keeps an=1111.
  - Stimulus: same with the macro undefined.
  - Required response: an=0111 with seg=1000000.
